dt_path_ctrl: RTL

DT_PATH_CTRL -- requirements
Module: dt_path_ctrl

---
 rtl/dt_ctrl_pkg.sv | 36 +++
 rtl/dt_cfg_shadow.sv | 65 ++++++
 rtl/dt_path_ctrl.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/dt_ctrl_pkg.sv
// dt_path_ctrl shared types and constants.
// FSM encoding, config addresses and reset defaults.
package dt_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_INIT   = 3'd1,
    S_WARMUP = 3'd2,
    S_RUN    = 3'd3,
    S_STALE  = 3'd4
  } dt_state_e;

  localparam logic [1:0] CFG_ALPHA  = 2'd0;
  localparam logic [1:0] CFG_KDT    = 2'd1;
  localparam logic [1:0] CFG_DMAX   = 2'd2;
  localparam logic [1:0] CFG_COMMIT = 2'd3;

  localparam logic [7:0] ALPHA_RST_DEF = 8'd32;
  localparam logic [7:0] KDT_RST_DEF   = 8'd2;
  localparam logic [7:0] DMAX_RST_DEF  = 8'd64;

  localparam logic [7:0] KDT_MAX = 8'd7;

  typedef struct packed {
    logic [7:0] alpha;
    logic [7:0] k_dt;
    logic [7:0] d_max;
  } dt_cfg_t;

  function automatic logic [7:0] clamp_kdt(
    input logic [7:0] v
  );
    return (v > KDT_MAX) ? KDT_MAX : v;
  endfunction

endpackage

// File: rtl/dt_cfg_shadow.sv
// Shadow/active estimator config with deferred commit.
// Commit applies on the next allowed strobe.
module dt_cfg_shadow
  import dt_ctrl_pkg::*;
#(
  parameter logic [7:0] ALPHA_RST = ALPHA_RST_DEF,
  parameter logic [7:0] KDT_RST   = KDT_RST_DEF,
  parameter logic [7:0] DMAX_RST  = DMAX_RST_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cfg_we_i,
  input  logic [1:0] cfg_addr_i,
  input  logic [7:0] cfg_wdata_i,
  input  logic       t_stb_i,
  input  logic       apply_en_i,
  output logic       apply_o,
  output dt_cfg_t    act_o
);

  dt_cfg_t shd_q, shd_d;
  dt_cfg_t act_q, act_d;
  logic    pend_q, pend_d;
  logic    apply;

  assign apply   = pend_q & t_stb_i & apply_en_i;
  assign apply_o = apply;
  assign act_o   = act_q;

  // Apply reads the old shadow, so a same-cycle write waits
  always_comb begin
    shd_d  = shd_q;
    act_d  = act_q;
    pend_d = pend_q & ~apply;
    if (apply) begin
      act_d      = shd_q;
      act_d.k_dt = clamp_kdt(shd_q.k_dt);
    end
    if (cfg_we_i) begin
      unique case (cfg_addr_i)
        CFG_ALPHA:  shd_d.alpha = cfg_wdata_i;
        CFG_KDT:    shd_d.k_dt  = cfg_wdata_i;
        CFG_DMAX:   shd_d.d_max = cfg_wdata_i;
        CFG_COMMIT: pend_d      = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shd_q.alpha <= ALPHA_RST;
      shd_q.k_dt  <= KDT_RST;
      shd_q.d_max <= DMAX_RST;
      act_q.alpha <= ALPHA_RST;
      act_q.k_dt  <= KDT_RST;
      act_q.d_max <= DMAX_RST;
      pend_q      <= 1'b0;
    end else begin
      shd_q  <= shd_d;
      act_q  <= act_d;
      pend_q <= pend_d;
    end
  end

endmodule

// File: rtl/dt_path_ctrl.sv
// dT path controller: source select, warmup,
// stale detection and estimator sequencing.
module dt_path_ctrl
  import dt_ctrl_pkg::*;
#(
  parameter int unsigned WARMUP_N    = 4,
  parameter int unsigned TIMEOUT_CYC = 1024,
  parameter logic [7:0]  ALPHA_RST   = ALPHA_RST_DEF,
  parameter logic [7:0]  KDT_RST     = KDT_RST_DEF,
  parameter logic [7:0]  DMAX_RST    = DMAX_RST_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              dt_mode,
  input  logic              t_stb,
  input  logic signed [7:0] T_in,
  input  logic signed [7:0] dT_ext,
  input  logic              dT_ext_vld,
  input  logic              cfg_we,
  input  logic [1:0]        cfg_addr,
  input  logic [7:0]        cfg_wdata,
  input  logic signed [7:0] est_dT,
  output logic signed [7:0] est_T_cur,
  output logic [7:0]        est_alpha,
  output logic [7:0]        est_k_dt,
  output logic [7:0]        est_d_max,
  output logic              est_init,
  output logic signed [7:0] dT_out,
  output logic              dt_valid,
  output logic              dt_src,
  output logic [2:0]        state
);

  localparam int unsigned CW =
    $clog2(TIMEOUT_CYC + 1);
  localparam logic [CW-1:0] TO_M1 =
    CW'(TIMEOUT_CYC - 1);
  localparam logic [CW-1:0] TO_MAX =
    CW'(TIMEOUT_CYC);
  localparam logic [3:0] WN_M1 =
    4'(WARMUP_N - 1);

  dt_state_e         state_q, state_d;
  logic              src_q, src_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [3:0]        wcnt_q, wcnt_d;
  logic              p1_q, p1_d;
  logic              p2_q, p2_d;
  logic signed [7:0] tcur_q, tcur_d;
  logic signed [7:0] dto_q, dto_d;
  logic              vld_q, vld_d;

  logic    apply;
  logic    apply_en;
  logic    in_wr;
  logic    mode_chg;
  logic    tmo;
  logic    run_ok;
  dt_cfg_t act;

  assign apply_en = (state_q != S_INIT);

  dt_cfg_shadow #(
    .ALPHA_RST (ALPHA_RST),
    .KDT_RST   (KDT_RST),
    .DMAX_RST  (DMAX_RST)
  ) u_cfg (
    .clk         (clk),
    .rst_n       (rst_n),
    .cfg_we_i    (cfg_we),
    .cfg_addr_i  (cfg_addr),
    .cfg_wdata_i (cfg_wdata),
    .t_stb_i     (t_stb),
    .apply_en_i  (apply_en),
    .apply_o     (apply),
    .act_o       (act)
  );

  assign in_wr = (state_q == S_WARMUP) ||
                 (state_q == S_RUN);
  // Mode change is judged against the source latched at INIT
  assign mode_chg = in_wr && (dt_mode != src_q);
  assign tmo = in_wr && !t_stb &&
               (cnt_q == TO_M1);

  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    wcnt_d  = wcnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (t_stb) state_d = S_INIT;
      end
      S_INIT: begin
        src_d   = dt_mode;
        wcnt_d  = '0;
        state_d = dt_mode ? S_WARMUP : S_RUN;
      end
      S_WARMUP: begin
        if (apply || mode_chg) begin
          state_d = S_INIT;
        end else if (t_stb) begin
          if (wcnt_q == WN_M1) state_d = S_RUN;
          else wcnt_d = wcnt_q + 4'd1;
        end else if (tmo) begin
          state_d = S_STALE;
        end
      end
      S_RUN: begin
        if (apply || mode_chg) state_d = S_INIT;
        else if (tmo) state_d = S_STALE;
      end
      S_STALE: begin
        if (t_stb) state_d = S_INIT;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    cnt_d = cnt_q;
    if (t_stb || state_q == S_IDLE ||
        state_q == S_INIT) begin
      cnt_d = '0;
    end else if (cnt_q != TO_MAX) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  assign run_ok = (state_q == S_RUN) &&
                  (state_d == S_RUN);

  always_comb begin
    p1_d   = run_ok & src_q & t_stb;
    p2_d   = p1_q;
    tcur_d = t_stb ? T_in : tcur_q;
    dto_d  = dto_q;
    vld_d  = 1'b0;
    if (state_d == S_INIT) begin
      dto_d = '0;
    end else if (run_ok) begin
      if (src_q) begin
        if (p2_q) begin
          dto_d = est_dT;
          vld_d = 1'b1;
        end
      end else if (dT_ext_vld) begin
        dto_d = dT_ext;
        vld_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      src_q   <= 1'b0;
      cnt_q   <= '0;
      wcnt_q  <= '0;
      p1_q    <= 1'b0;
      p2_q    <= 1'b0;
      tcur_q  <= '0;
      dto_q   <= '0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      cnt_q   <= cnt_d;
      wcnt_q  <= wcnt_d;
      p1_q    <= p1_d;
      p2_q    <= p2_d;
      tcur_q  <= tcur_d;
      dto_q   <= dto_d;
      vld_q   <= vld_d;
    end
  end

  assign est_T_cur = tcur_q;
  assign est_alpha = act.alpha;
  assign est_k_dt  = act.k_dt;
  assign est_d_max = act.d_max;
  assign est_init  = (state_q == S_INIT);
  assign dT_out    = dto_q;
  assign dt_valid  = vld_q;
  assign dt_src    = src_q;
  assign state     = state_q;

endmodule
